// File: rtl/mem_arbiter_2to1_if.sv
// Fetch, data and memory-side handshake signals of mem_arbiter_2to1.
// slave: the arbiter's view. master: the core + RAM environment's view.
interface mem_arbiter_2to1_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_rdata;
    logic              i_ready;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ready;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
        output i_rdata, i_ready, d_rdata, d_ready, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
        input  i_rdata, i_ready, d_rdata, d_ready, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter_2to1.sv
// Data-priority 2:1 arbiter (fetch vs load/store) onto one req/ack memory port,
// with a streak limit for fetch fairness. Define ARB_TIMEOUT_EN for the wait watchdog and err.
module mem_arbiter_2to1 #(
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int DATA_MAX_STREAK = 3,
    parameter int TIMEOUT_CYCLES  = 64
) (
    input  logic              clk,
    input  logic              rst,
    mem_arbiter_2to1_if.slave bus,
    output logic              err
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_I_WAIT = 2'd1;
    localparam logic [1:0] S_D_WAIT = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    localparam logic [3:0] STREAK_MAX = 4'(DATA_MAX_STREAK);

    if (DATA_MAX_STREAK < 1 || DATA_MAX_STREAK > 15) begin : g_bad_streak
        $error("mem_arbiter_2to1: DATA_MAX_STREAK must be 1..15");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("mem_arbiter_2to1: TIMEOUT_CYCLES must be >= 1");
    end

    logic [1:0]        state_q, state_d;
    logic [3:0]        streak_q, streak_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic              i_ready_q, i_ready_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              d_ready_q, d_ready_d;

    logic              done;
    logic [DATA_W-1:0] rsp;

`ifdef ARB_TIMEOUT_EN
    localparam int                WAIT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              err_q, err_d;
`endif

    always_comb begin
        state_d     = state_q;
        streak_d    = streak_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        i_rdata_d   = i_rdata_q;
        i_ready_d   = i_ready_q;
        d_rdata_d   = d_rdata_q;
        d_ready_d   = d_ready_q;
        done        = 1'b0;
        rsp         = bus.mem_rdata;
`ifdef ARB_TIMEOUT_EN
        wait_d      = wait_q;
        err_d       = err_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (!bus.d_req) streak_d = '0;
`ifdef ARB_TIMEOUT_EN
                wait_d = '0;
`endif
                if (bus.d_req && (!bus.i_req || streak_q < STREAK_MAX)) begin
                    state_d     = S_D_WAIT;
                    mem_req_d   = 1'b1;
                    mem_we_d    = bus.d_we;
                    mem_addr_d  = bus.d_addr;
                    mem_wdata_d = bus.d_wdata;
                    streak_d    = (streak_q == STREAK_MAX) ? streak_q : streak_q + 4'd1;
                end else if (bus.i_req) begin
                    state_d     = S_I_WAIT;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = bus.i_addr;
                    mem_wdata_d = '0;
                    streak_d    = '0;
                end
            end

            S_I_WAIT, S_D_WAIT: begin
                done = bus.mem_ack;
`ifdef ARB_TIMEOUT_EN
                // Watchdog expiry completes the access like an ack, with a poison word.
                if (!bus.mem_ack) begin
                    if (wait_q == WAIT_LAST) begin
                        done  = 1'b1;
                        rsp   = DATA_W'(32'hDEAD_BEEF);
                        err_d = 1'b1;
                    end else begin
                        wait_d = wait_q + WAIT_W'(1);
                    end
                end
`endif
                if (done) begin
                    state_d   = S_RESP;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    if (state_q == S_I_WAIT) begin
                        i_rdata_d = rsp;
                        i_ready_d = 1'b1;
                    end else begin
                        if (!mem_we_q) d_rdata_d = rsp;
                        d_ready_d = 1'b1;
                    end
                end
            end

            S_RESP: begin
                state_d   = S_IDLE;
                i_ready_d = 1'b0;
                d_ready_d = 1'b0;
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            streak_q    <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            i_rdata_q   <= '0;
            i_ready_q   <= 1'b0;
            d_rdata_q   <= '0;
            d_ready_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            streak_q    <= streak_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            i_rdata_q   <= i_rdata_d;
            i_ready_q   <= i_ready_d;
            d_rdata_q   <= d_rdata_d;
            d_ready_q   <= d_ready_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_q <= '0;
            err_q  <= 1'b0;
        end else begin
            wait_q <= wait_d;
            err_q  <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.i_rdata   = i_rdata_q;
    assign bus.i_ready   = i_ready_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.d_ready   = d_ready_q;
endmodule

// File: tb/tb_mem_arbiter_2to1.sv
// Bench for mem_arbiter_2to1: transaction-level arbitration model plus directed and random traffic.
module tb_mem_arbiter_2to1;
    localparam int STREAK = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic err;
    always #5 clk = ~clk;

    mem_arbiter_2to1_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_arbiter_2to1 #(
        .ADDR_W(32), .DATA_W(32), .DATA_MAX_STREAK(STREAK), .TIMEOUT_CYCLES(64)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus), .err(err)
    );

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
    } item_t;

    int n_total = 0;
    int n_pass  = 0;

    // requester and RAM environment
    item_t iq[$], dq[$];
    item_t i_cur, d_cur;
    bit    i_act = 0, d_act = 0;
    logic [31:0] emem [256];
    logic [31:0] mref [256];
    bit    mem_busy = 0;
    int    mem_cnt = 0;
    int    lat_fixed = 0;
    logic [31:0] slow_addr = 32'hFFFF_FFFF;

    // reference model: current owner (0 none, 1 fetch, 2 data), response cycle, streak
    int  m_owner = 0;
    bit  m_resp = 0;
    int  m_streak = 0;
    int  m_gcyc = 0;
    int  cyc = 0;
    int  gq[$];
    int  lat_q[$];
    logic        e_mem_req = 0, e_mem_we = 0, e_i_ready = 0, e_d_ready = 0;
    logic [31:0] e_mem_addr = '0, e_mem_wdata = '0, e_i_rdata = '0, e_d_rdata = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic model_reset();
        m_owner = 0; m_resp = 0; m_streak = 0;
        e_mem_req = 0; e_mem_we = 0; e_i_ready = 0; e_d_ready = 0;
        e_mem_addr = '0; e_mem_wdata = '0; e_i_rdata = '0; e_d_rdata = '0;
    endtask

    task automatic model_step();
        if (m_resp) begin
            m_resp = 0; e_i_ready = 0; e_d_ready = 0;
        end else if (m_owner == 0) begin
            if (!bus.d_req) m_streak = 0;
            if (bus.d_req && (!bus.i_req || m_streak < STREAK)) begin
                m_owner = 2;
                m_streak = (m_streak < STREAK) ? m_streak + 1 : STREAK;
                e_mem_we = bus.d_we; e_mem_addr = bus.d_addr; e_mem_wdata = bus.d_wdata;
            end else if (bus.i_req) begin
                m_owner = 1; m_streak = 0;
                e_mem_we = 0; e_mem_addr = bus.i_addr;
            end
            if (m_owner != 0) begin
                e_mem_req = 1; m_gcyc = cyc; gq.push_back(m_owner);
            end
        end else if (bus.mem_ack) begin
            if (m_owner == 1) begin
                e_i_rdata = mref[e_mem_addr[9:2]]; e_i_ready = 1;
            end else begin
                if (e_mem_we) mref[e_mem_addr[9:2]] = e_mem_wdata;
                else e_d_rdata = mref[e_mem_addr[9:2]];
                e_d_ready = 1;
            end
            lat_q.push_back(cyc + 1 - m_gcyc);
            m_owner = 0; m_resp = 1; e_mem_req = 0; e_mem_we = 0;
        end
    endtask

    task automatic env_reset();
        iq.delete(); dq.delete();
        i_act = 0; d_act = 0; mem_busy = 0;
        bus.i_req = 0; bus.d_req = 0; bus.mem_ack = 0;
    endtask

    task automatic env_step();
        if (i_act && bus.i_ready) i_act = 0;
        if (!i_act && iq.size() > 0) begin i_cur = iq.pop_front(); i_act = 1; end
        bus.i_req = i_act; bus.i_addr = i_cur.addr;
        if (d_act && bus.d_ready) d_act = 0;
        if (!d_act && dq.size() > 0) begin d_cur = dq.pop_front(); d_act = 1; end
        bus.d_req = d_act; bus.d_we = d_cur.we; bus.d_addr = d_cur.addr; bus.d_wdata = d_cur.wdata;

        bus.mem_ack = 0;
        bus.mem_rdata = $urandom;
        if (bus.mem_req) begin
            if (!mem_busy) begin
                mem_busy = 1;
                mem_cnt = (bus.mem_addr == slow_addr) ? 20 :
                          (lat_fixed >= 0) ? lat_fixed : int'($urandom_range(4, 0));
            end
            if (mem_cnt == 0) begin
                bus.mem_ack = 1; mem_busy = 0;
                if (bus.mem_we) emem[bus.mem_addr[9:2]] = bus.mem_wdata;
                else bus.mem_rdata = emem[bus.mem_addr[9:2]];
            end else begin
                mem_cnt--;
            end
        end else begin
            bus.mem_ack = ($urandom_range(3, 0) == 0);   // ack with no request must be ignored
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        #1;
        if (!rst) begin model_step(); env_step(); end
    endtask

    task automatic run_idle(input string name, input int budget);
        int n = 0;
        while ((iq.size() > 0 || dq.size() > 0 || i_act || d_act || m_owner != 0 || m_resp)
               && n < budget) begin
            step(); n++;
        end
        check(name, 32'(n < budget), 32'd1);
    endtask

    function automatic logic [31:0] pack_grants(input int from, input int n);
        logic [31:0] v = '0;
        for (int k = 0; k < n; k++)
            v = {v[29:0], (from + k < gq.size()) ? 2'(gq[from + k]) : 2'b00};
        return v;
    endfunction

    function automatic item_t mk(input logic [31:0] a, input logic w, input logic [31:0] wd);
        item_t it;
        it.addr = a; it.we = w; it.wdata = wd;
        return it;
    endfunction

    always @(negedge clk) begin
        check("mem_req", bus.mem_req, e_mem_req);
        if (e_mem_req) begin
            check("mem_we", bus.mem_we, e_mem_we);
            check("mem_addr", bus.mem_addr, e_mem_addr);
            if (e_mem_we) check("mem_wdata", bus.mem_wdata, e_mem_wdata);
        end
        check("i_ready", bus.i_ready, e_i_ready);
        check("d_ready", bus.d_ready, e_d_ready);
        check("i_rdata", bus.i_rdata, e_i_rdata);
        check("d_rdata", bus.d_rdata, e_d_rdata);
        check("err", err, 32'd0);
    end

    initial begin
        int gb, lb, n;
        for (int k = 0; k < 256; k++) begin
            emem[k] = 32'h1000_0000 + k * 32'h0001_0101;
            mref[k] = emem[k];
        end
        emem[64] = 32'h0050_0093; mref[64] = 32'h0050_0093;   // word at 0x100
        i_cur = mk('0, 0, '0); d_cur = mk('0, 0, '0);
        bus.i_req = 0; bus.i_addr = '0; bus.d_req = 0; bus.d_we = 0;
        bus.d_addr = '0; bus.d_wdata = '0; bus.mem_rdata = '0; bus.mem_ack = 0;

        repeat (3) step();
        check("rst mem_req", bus.mem_req, 32'd0);
        check("rst i_ready", bus.i_ready, 32'd0);
        check("rst d_ready", bus.d_ready, 32'd0);
        check("rst rdata", bus.i_rdata | bus.d_rdata, 32'd0);
        #1 rst = 0;

        // fetch only, zero-wait memory
        lat_fixed = 0; gb = gq.size(); lb = lat_q.size();
        iq.push_back(mk(32'h100, 0, '0));
        run_idle("t1 done", 50);
        check("t1 grants", pack_grants(gb, 2), 32'h4);
        check("t1 latency", lat_q[lb], 32'd2);
        check("t1 i_rdata", bus.i_rdata, 32'h0050_0093);

        // store then load same word
        dq.push_back(mk(32'h2000, 1, 32'hCAFE_F00D));
        dq.push_back(mk(32'h2000, 0, '0));
        run_idle("t2 done", 50);
        check("t2 d_rdata", bus.d_rdata, 32'hCAFE_F00D);
        check("t2 model", e_d_rdata, 32'hCAFE_F00D);

        // contention, both requesters re-request immediately
        gb = gq.size();
        for (int k = 0; k < 8; k++) begin
            iq.push_back(mk(32'h2040 + 32'(4 * k), 0, '0));
            dq.push_back(mk(32'h2000 + 32'(4 * k), 0, '0));
        end
        run_idle("t3 done", 200);
        check("t3 order DDDIDDDI", pack_grants(gb, 8), 32'hA9A9);

        // five memory wait cycles
        lat_fixed = 5; lb = lat_q.size();
        dq.push_back(mk(32'h2004, 0, '0));
        run_idle("t4 done", 50);
        check("t4 latency", lat_q[lb], 32'd7);

        // streak builds to 3, then reset during a slow store
        lat_fixed = 0; slow_addr = 32'h2008;
        dq.push_back(mk(32'h2000, 0, '0));
        dq.push_back(mk(32'h2004, 0, '0));
        dq.push_back(mk(32'h2008, 1, 32'h1234_5678));
        n = 0;
        while (!(m_owner == 2 && e_mem_we) && n < 40) begin step(); n++; end
        check("t5 store granted", 32'(n < 40), 32'd1);
        step(); step();
        #2 rst = 1;
        #1;
        check("t5 async mem_req", bus.mem_req, 32'd0);
        check("t5 async d_ready", bus.d_ready, 32'd0);
        check("t5 async i_ready", bus.i_ready, 32'd0);
        check("t5 async err", err, 32'd0);
        model_reset(); env_reset();
        step(); step();
        #2 rst = 0;
        slow_addr = 32'hFFFF_FFFF;
        gb = gq.size();
        for (int k = 0; k < 4; k++) dq.push_back(mk(32'h2010 + 32'(4 * k), 0, '0));
        iq.push_back(mk(32'h100, 0, '0));
        run_idle("t5 contention done", 100);
        check("t5 order DDDI", pack_grants(gb, 4), 32'hA9);
        gb = gq.size();
        iq.push_back(mk(32'h2044, 0, '0));
        run_idle("t5 fetch done", 50);
        check("t5 fetch alone", pack_grants(gb, 1), 32'h1);

        // random traffic and random memory latency
        lat_fixed = -1;
        repeat (2500) begin
            if (iq.size() == 0 && $urandom_range(2, 0) == 0)
                iq.push_back(mk(32'h2000 + 32'(4 * $urandom_range(31, 0)), 0, '0));
            if (dq.size() == 0 && $urandom_range(2, 0) == 0)
                dq.push_back(mk(32'h2000 + 32'(4 * $urandom_range(31, 0)),
                                1'($urandom_range(1, 0)), $urandom));
            step();
        end
        run_idle("drain", 200);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
